// File: rtl/keypad_entry_ctrl.sv
// Keypad number-entry sequencer: press gate, 8-digit BCD edit buffer, BCD-to-binary commit, valid/ack hold.
// Optional KEYPAD_ENTRY_NEG_EN adds an 'A'-toggled sign flag and a two's-complement commit.
module keypad_entry_ctrl #(
  parameter int unsigned RELEASE_CYCLES = 3_000_000,
  parameter int unsigned MAX_DIGITS     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  key_coord,
  input  logic        req,
  input  logic        ack,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        entry_active,
  output logic [3:0]  digit_cnt,
  output logic [31:0] bcd_digits
);

  localparam int unsigned CW = $clog2(RELEASE_CYCLES + 1);

  localparam logic [3:0] KEY_A     = 4'd10;
  localparam logic [3:0] KEY_D     = 4'd13;
  localparam logic [3:0] KEY_STAR  = 4'd14;
  localparam logic [3:0] KEY_HASH  = 4'd15;

  typedef enum logic {G_ARMED, G_HELD} gate_t;
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONVERT, S_DONE} state_t;

  // {valid, index} for an active-low one-hot nibble
  function automatic logic [2:0] decode_nibble(input logic [3:0] n);
    case (n)
      4'b0111: decode_nibble = 3'b100;
      4'b1011: decode_nibble = 3'b101;
      4'b1101: decode_nibble = 3'b110;
      4'b1110: decode_nibble = 3'b111;
      default: decode_nibble = 3'b000;
    endcase
  endfunction

  // Codes 0-9 are the digits themselves; 10-13 = A-D, 14 = '*', 15 = '#'
  function automatic logic [3:0] key_map(input logic [3:0] rc);
    case (rc)
      4'd0:  key_map = 4'd1;   4'd1:  key_map = 4'd2;
      4'd2:  key_map = 4'd3;   4'd3:  key_map = KEY_A;
      4'd4:  key_map = 4'd4;   4'd5:  key_map = 4'd5;
      4'd6:  key_map = 4'd6;   4'd7:  key_map = 4'd11;
      4'd8:  key_map = 4'd7;   4'd9:  key_map = 4'd8;
      4'd10: key_map = 4'd9;   4'd11: key_map = 4'd12;
      4'd12: key_map = KEY_STAR; 4'd13: key_map = 4'd0;
      4'd14: key_map = KEY_HASH; default: key_map = KEY_D;
    endcase
  endfunction

  logic [7:0]    key_reg;
  gate_t         gate_reg, gate_next;
  logic [CW-1:0] gate_cnt_reg, gate_cnt_next;
  logic          press_reg, press_next;
  logic [3:0]    press_code_reg, press_code_next;

  state_t        state_reg, state_next;
  logic [31:0]   bcd_reg, bcd_next;
  logic [3:0]    digit_cnt_reg, digit_cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [31:0]   acc_reg, acc_next;
  logic [31:0]   value_reg, value_next;
`ifdef KEYPAD_ENTRY_NEG_EN
  logic          sign_reg, sign_next;
`endif

  logic [2:0] row_dec, col_dec;
  logic       key_ok, key_zero;
  logic [3:0] nib;

  assign row_dec  = decode_nibble(key_reg[7:4]);
  assign col_dec  = decode_nibble(key_reg[3:0]);
  assign key_ok   = row_dec[2] & col_dec[2];
  assign key_zero = (key_reg == 8'd0);
  assign nib      = 4'(bcd_reg >> {idx_reg - 4'd1, 2'b00});

  always_comb begin
    gate_next       = gate_reg;
    gate_cnt_next   = gate_cnt_reg;
    press_next      = 1'b0;
    press_code_next = press_code_reg;
    case (gate_reg)
      G_ARMED: begin
        if (key_ok) begin
          press_next      = 1'b1;
          press_code_next = key_map({row_dec[1:0], col_dec[1:0]});
          gate_next       = G_HELD;
          gate_cnt_next   = '0;
        end
      end
      default: begin
        // Invalid (non one-hot) codes neither clear nor advance the counter
        if (key_ok) begin
          gate_cnt_next = '0;
        end else if (key_zero) begin
          if (gate_cnt_reg == CW'(RELEASE_CYCLES - 1)) begin
            gate_next     = G_ARMED;
            gate_cnt_next = '0;
          end else begin
            gate_cnt_next = gate_cnt_reg + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    bcd_next       = bcd_reg;
    digit_cnt_next = digit_cnt_reg;
    idx_next       = idx_reg;
    acc_next       = acc_reg;
    value_next     = value_reg;
`ifdef KEYPAD_ENTRY_NEG_EN
    sign_next      = sign_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          state_next     = S_ENTRY;
          bcd_next       = '0;
          digit_cnt_next = '0;
`ifdef KEYPAD_ENTRY_NEG_EN
          sign_next      = 1'b0;
`endif
        end
      end
      S_ENTRY: begin
        if (press_reg) begin
          if (press_code_reg <= 4'd9) begin
            if (digit_cnt_reg < 4'(MAX_DIGITS)) begin
              bcd_next       = {bcd_reg[27:0], press_code_reg};
              digit_cnt_next = digit_cnt_reg + 4'd1;
            end
          end else if (press_code_reg == KEY_STAR) begin
            if (digit_cnt_reg != 4'd0) begin
              bcd_next       = bcd_reg >> 4;
              digit_cnt_next = digit_cnt_reg - 4'd1;
            end
          end else if (press_code_reg == KEY_D) begin
            bcd_next       = '0;
            digit_cnt_next = '0;
`ifdef KEYPAD_ENTRY_NEG_EN
            sign_next      = 1'b0;
`endif
          end else if (press_code_reg == KEY_HASH) begin
            state_next = S_CONVERT;
            acc_next   = '0;
            idx_next   = digit_cnt_reg;
`ifdef KEYPAD_ENTRY_NEG_EN
          end else if (press_code_reg == KEY_A) begin
            sign_next = ~sign_reg;
`endif
          end
        end
      end
      S_CONVERT: begin
        // Most significant digit first: acc*10 + next nibble
        if (idx_reg != 4'd0) begin
          acc_next = (acc_reg << 3) + (acc_reg << 1) + {28'd0, nib};
          idx_next = idx_reg - 4'd1;
        end else begin
`ifdef KEYPAD_ENTRY_NEG_EN
          value_next = sign_reg ? (~acc_reg + 32'd1) : acc_reg;
`else
          value_next = acc_reg;
`endif
          state_next = S_DONE;
        end
      end
      default: begin
        if (ack) state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg        <= '0;
      gate_reg       <= G_ARMED;
      gate_cnt_reg   <= '0;
      press_reg      <= 1'b0;
      press_code_reg <= '0;
      state_reg      <= S_IDLE;
      bcd_reg        <= '0;
      digit_cnt_reg  <= '0;
      idx_reg        <= '0;
      acc_reg        <= '0;
      value_reg      <= '0;
`ifdef KEYPAD_ENTRY_NEG_EN
      sign_reg       <= 1'b0;
`endif
    end else begin
      key_reg        <= key_coord;
      gate_reg       <= gate_next;
      gate_cnt_reg   <= gate_cnt_next;
      press_reg      <= press_next;
      press_code_reg <= press_code_next;
      state_reg      <= state_next;
      bcd_reg        <= bcd_next;
      digit_cnt_reg  <= digit_cnt_next;
      idx_reg        <= idx_next;
      acc_reg        <= acc_next;
      value_reg      <= value_next;
`ifdef KEYPAD_ENTRY_NEG_EN
      sign_reg       <= sign_next;
`endif
    end
  end

  assign value        = value_reg;
  assign value_valid  = (state_reg == S_DONE);
  assign entry_active = (state_reg == S_ENTRY);
  assign digit_cnt    = digit_cnt_reg;
  assign bcd_digits   = bcd_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with RELEASE_CYCLES=16; inputs driven and outputs sampled on negedge.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  key_coord;
  logic        req;
  logic        ack;
  logic [31:0] value;
  logic        value_valid;
  logic        entry_active;
  logic [3:0]  digit_cnt;
  logic [31:0] bcd_digits;

  int checks = 0;
  int errors = 0;

  keypad_entry_ctrl #(.RELEASE_CYCLES(16), .MAX_DIGITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .req(req), .ack(ack),
    .value(value), .value_valid(value_valid), .entry_active(entry_active),
    .digit_cnt(digit_cnt), .bcd_digits(bcd_digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One-cycle scanner pulse; returns on the negedge where key_coord is cleared
  task automatic pulse(input logic [7:0] code);
    key_coord = code;
    @(negedge clk);
    key_coord = 8'h00;
  endtask

  // Full press: pulse then enough silence to re-arm the gate
  task automatic press(input logic [7:0] code);
    pulse(code);
    repeat (20) @(negedge clk);
  endtask

  task automatic start_session();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("session_start_active", {31'd0, entry_active}, 32'd1);
    check("session_start_cnt", {28'd0, digit_cnt}, 32'd0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid_low", {31'd0, value_valid}, 32'd0);
    check("ack_idle", {31'd0, entry_active}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; key_coord = 8'h00; req = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_value", value, 32'd0);
    check("rst_valid", {31'd0, value_valid}, 32'd0);
    check("rst_active", {31'd0, entry_active}, 32'd0);
    check("rst_cnt", {28'd0, digit_cnt}, 32'd0);
    check("rst_bcd", bcd_digits, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1,2,3,# -> 123 with valid 4 cycles after CONVERT entry
    start_session();
    press(8'h77); press(8'h7B); press(8'h7D);
    check("t1_cnt", {28'd0, digit_cnt}, 32'd3);
    check("t1_bcd", bcd_digits, 32'h0000_0123);
    pulse(8'hED);
    repeat (5) @(negedge clk);
    check("t1_valid_early", {31'd0, value_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid", {31'd0, value_valid}, 32'd1);
    check("t1_value", value, 32'd123);
    check("t1_cnt_done", {28'd0, digit_cnt}, 32'd3);
    check("t1_bcd_done", bcd_digits, 32'h0000_0123);
    repeat (15) @(negedge clk);
    do_ack();
    check("t1_value_hold", value, 32'd123);

    // Repeating scanner code accepted once
    start_session();
    for (int i = 0; i < 10; i++) begin
      pulse(8'hBB);
      repeat (8) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("t2_bounce_cnt", {28'd0, digit_cnt}, 32'd1);
    check("t2_bounce_bcd", bcd_digits, 32'h0000_0005);
    press(8'hEE);
    check("t2_clear_cnt", {28'd0, digit_cnt}, 32'd0);
    check("t2_clear_bcd", bcd_digits, 32'd0);
    press(8'h77); press(8'h7B); press(8'hE7);
    check("t2_del_cnt", {28'd0, digit_cnt}, 32'd1);
    check("t2_del_bcd", bcd_digits, 32'h0000_0001);
    press(8'h7D); press(8'hED);
    check("t2_valid", {31'd0, value_valid}, 32'd1);
    check("t2_value", value, 32'd13);
    do_ack();

    // Invalid code ignored, nine 9s capped at eight digits
    start_session();
    press(8'h3F);
    check("t3_invalid_cnt", {28'd0, digit_cnt}, 32'd0);
    for (int i = 0; i < 9; i++) press(8'hDD);
    check("t3_max_cnt", {28'd0, digit_cnt}, 32'd8);
    check("t3_max_bcd", bcd_digits, 32'h9999_9999);
    press(8'hED);
    check("t3_value", value, 32'd99_999_999);
    do_ack();

    // Reset during the second CONVERT cycle
    start_session();
    press(8'h77); press(8'h7B);
    pulse(8'hED);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_value", value, 32'd0);
    check("t4_valid", {31'd0, value_valid}, 32'd0);
    check("t4_cnt", {28'd0, digit_cnt}, 32'd0);
    check("t4_active", {31'd0, entry_active}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 'A', 4, 2, # -> sign depends on build option
    start_session();
    press(8'h7E); press(8'hB7); press(8'h7B);
    check("t5_bcd", bcd_digits, 32'h0000_0042);
    press(8'hED);
`ifdef KEYPAD_ENTRY_NEG_EN
    check("t5_value", value, 32'hFFFF_FFD6);
`else
    check("t5_value", value, 32'd42);
`endif
    do_ack();

    // '*' at zero digits, then '#' with no digits: valid 1 cycle after CONVERT entry
    start_session();
    press(8'hE7);
    check("t6_del_empty", {28'd0, digit_cnt}, 32'd0);
    pulse(8'hED);
    repeat (2) @(negedge clk);
    check("t6_valid_early", {31'd0, value_valid}, 32'd0);
    @(negedge clk);
    check("t6_valid", {31'd0, value_valid}, 32'd1);
    check("t6_value", value, 32'd0);
    repeat (15) @(negedge clk);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
